sa_sched_ctrl: RTL and testbench

Sequencer for one weight-stationary ROWS x COLS systolic array of PE tiles.
- It runs three phases per job: weight load (PE mode 0), activation streaming (PE mode 1), and pipeline drain.
- Per-row skewed activation valids and per-column result valids/indices are generated here, so edge buffers need no timing logic.
- It sits between the job-level start/done interface and the array plus its weight, activation and result buffers.

---
 rtl/sa_ctrl_pkg.sv | 16 +
 rtl/sa_delay_line.sv | 39 +++
 rtl/sa_sched_ctrl.sv | 147 ++++++++++++++
 tb/tb_sa_sched_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared types for the systolic-array scheduler.
// Holds the phase encoding and the PE mode constants.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

endpackage

// File: rtl/sa_delay_line.sv
// Valid+data shift register with synchronous flush.
// Output appears DEPTH cycles after the input is presented.
module sa_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic [DEPTH-1:0] v_q;
    logic [W-1:0]     d_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else if (i_flush) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
            v_q[0] <= i_valid;
            d_q[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign o_valid = v_q[DEPTH-1];
    assign o_data  = d_q[DEPTH-1];

endmodule

// File: rtl/sa_sched_ctrl.sv
// Job sequencer for a weight-stationary systolic array:
// weight load, activation streaming, drain, with per-row/column skew.
module sa_sched_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter  int ROWS     = 4,
    parameter  int COLS     = 4,
    parameter  int MAX_VECS = 256,
    localparam int VW       = $clog2(MAX_VECS + 1),
    localparam int RW       = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [VW-1:0]        i_num_vecs,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_mode,
    output logic                 o_w_valid,
    output logic [RW-1:0]        o_w_addr,
    output logic                 o_act_issue,
    output logic [VW-1:0]        o_act_addr,
    output logic [ROWS-1:0]      o_act_valid,
    output logic [COLS-1:0]      o_res_valid,
    output logic [COLS*VW-1:0]   o_res_idx
);

    localparam int DW = $clog2(ROWS + COLS);
    localparam int CW = (VW > DW) ? VW : DW;

    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(ROWS - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(ROWS + COLS - 2);
    localparam logic [RW-1:0] W_TOP      = RW'(ROWS - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [VW-1:0] n_q;
    logic [CW-1:0] comp_last;
    logic          act_issue;

    // n_q is never zero while in COMPUTE, so this cannot underflow there
    assign comp_last = CW'(n_q) - ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
        end else if (i_abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (i_start) begin
                        if (i_num_vecs == '0) begin
                            state_q <= DONE;
                        end else begin
                            n_q     <= i_num_vecs;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (cnt_q == LOAD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= COMPUTE;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                COMPUTE: begin
                    if (cnt_q == comp_last) begin
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign act_issue   = (state_q == COMPUTE);
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_mode      = (state_q == LOAD) ? MODE_LOAD : MODE_ACC;
    assign o_w_valid   = (state_q == LOAD);
    assign o_w_addr    = o_w_valid ? (W_TOP - cnt_q[RW-1:0]) : '0;
    assign o_act_issue = act_issue;
    assign o_act_addr  = act_issue ? cnt_q[VW-1:0] : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_act
        logic v;
        logic d;

        sa_delay_line #(
            .DEPTH (r + 1),
            .W     (1)
        ) u_dl (
            .clk     (clk),
            .rst     (rst),
            .i_flush (i_abort),
            .i_valid (act_issue),
            .i_data  (1'b1),
            .o_valid (v),
            .o_data  (d)
        );

        // payload bit is a constant marker that travels with the valid
        assign o_act_valid[r] = v & d;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_res
        sa_delay_line #(
            .DEPTH (ROWS + c),
            .W     (VW)
        ) u_dl (
            .clk     (clk),
            .rst     (rst),
            .i_flush (i_abort),
            .i_valid (act_issue),
            .i_data  (o_act_addr),
            .o_valid (o_res_valid[c]),
            .o_data  (o_res_idx[c*VW +: VW])
        );
    end

endmodule

// File: tb/tb_sa_sched_ctrl.sv
// Directed bench for sa_sched_ctrl (ROWS = COLS = 4, MAX_VECS = 256).
// Expected waveforms come from a cycle-indexed timing model of a job.
module tb_sa_sched_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int MAX_VECS = 256;
    localparam int VW       = $clog2(MAX_VECS + 1);
    localparam int RW       = $clog2(ROWS);

    logic                clk;
    logic                rst;
    logic                i_start;
    logic [VW-1:0]       i_num_vecs;
    logic                i_abort;
    logic                o_busy;
    logic                o_done;
    logic                o_mode;
    logic                o_w_valid;
    logic [RW-1:0]       o_w_addr;
    logic                o_act_issue;
    logic [VW-1:0]       o_act_addr;
    logic [ROWS-1:0]     o_act_valid;
    logic [COLS-1:0]     o_res_valid;
    logic [COLS*VW-1:0]  o_res_idx;

    int n_chk;
    int n_fail;

    sa_sched_ctrl #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .MAX_VECS (MAX_VECS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_num_vecs  (i_num_vecs),
        .i_abort     (i_abort),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mode      (o_mode),
        .o_w_valid   (o_w_valid),
        .o_w_addr    (o_w_addr),
        .o_act_issue (o_act_issue),
        .o_act_addr  (o_act_addr),
        .o_act_valid (o_act_valid),
        .o_res_valid (o_res_valid),
        .o_res_idx   (o_res_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_busy"},  32'(o_busy), 32'd0);
        chk({p, "_done"},  32'(o_done), 32'd0);
        chk({p, "_mode"},  32'(o_mode), 32'd1);
        chk({p, "_wv"},    32'(o_w_valid), 32'd0);
        chk({p, "_wa"},    32'(o_w_addr), 32'd0);
        chk({p, "_iss"},   32'(o_act_issue), 32'd0);
        chk({p, "_aa"},    32'(o_act_addr), 32'd0);
        chk({p, "_av"},    32'(o_act_valid), 32'd0);
        chk({p, "_rv"},    32'(o_res_valid), 32'd0);
        chk({p, "_ridx"},  32'(o_res_idx), 32'd0);
    endtask

    // Issue for vector k happens in cycle ROWS+1+k of a job (start = cycle 0).
    function automatic bit issued(input int n, input int t);
        return (n != 0) && (t > ROWS) && (t <= ROWS + n);
    endfunction

    task automatic chk_cycle(input int c, input int n, input int done_c);
        bit ld;
        bit cp;
        logic [ROWS-1:0] av;
        logic [COLS-1:0] rv;
        ld = (n != 0) && (c >= 1) && (c <= ROWS);
        cp = issued(n, c);
        chk("mode",   32'(o_mode), 32'(!ld));
        chk("wvalid", 32'(o_w_valid), 32'(ld));
        if (ld) chk("waddr", 32'(o_w_addr), 32'(ROWS - c));
        chk("issue",  32'(o_act_issue), 32'(cp));
        if (cp) chk("aaddr", 32'(o_act_addr), 32'(c - ROWS - 1));
        av = '0;
        for (int r = 0; r < ROWS; r++) av[r] = issued(n, c - r - 1);
        chk("actv", 32'(o_act_valid), 32'(av));
        rv = '0;
        for (int k = 0; k < COLS; k++) begin
            rv[k] = issued(n, c - ROWS - k);
            if (rv[k])
                chk($sformatf("ridx%0d", k), 32'(o_res_idx[k*VW +: VW]),
                    32'(c - ROWS - k - ROWS - 1));
        end
        chk("resv",   32'(o_res_valid), 32'(rv));
        chk("busy",   32'(o_busy), 32'd1);
        chk("done",   32'(o_done), 32'(c == done_c));
    endtask

    // Runs a job from a start pulse; returns early in cycle stop_at.
    task automatic run_job(input int n, input int restart_at, input int stop_at);
        int done_c;
        done_c = (n == 0) ? 1 : 2 * ROWS + COLS + n;
        i_start    = 1'b1;
        i_num_vecs = VW'(n);
        step();
        i_start = 1'b0;
        for (int c = 1; c <= done_c; c++) begin
            chk_cycle(c, n, done_c);
            if (c == stop_at) return;
            if (c == restart_at) begin
                i_start    = 1'b1;
                i_num_vecs = VW'(9);
            end
            step();
            i_start = 1'b0;
        end
        chk("post_busy", 32'(o_busy), 32'd0);
        chk("post_done", 32'(o_done), 32'd0);
        chk("post_mode", 32'(o_mode), 32'd1);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b0;
        i_start    = 1'b0;
        i_num_vecs = '0;
        i_abort    = 1'b0;
        repeat (3) step();
        chk_reset_vals("rst");
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_reset_vals("idle");

        run_job(3, 0, 0);
        run_job(0, 0, 0);
        run_job(3, 5, 0);

        // Abort in COMPUTE: next cycle idle with skew flushed.
        run_job(3, 0, 6);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk_reset_vals("abort7");
        step();
        chk("abort8_done", 32'(o_done), 32'd0);
        chk("abort8_rv",   32'(o_res_valid), 32'd0);
        run_job(3, 0, 0);

        // Abort beats start in IDLE.
        i_start    = 1'b1;
        i_abort    = 1'b1;
        i_num_vecs = VW'(2);
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("abst_busy", 32'(o_busy), 32'd0);
        chk("abst_mode", 32'(o_mode), 32'd1);
        step();
        chk("abst_busy2", 32'(o_busy), 32'd0);

        // Async reset mid-DRAIN, then a fresh single-vector job.
        run_job(3, 0, 10);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("arst_idle", 32'(o_busy), 32'd0);
        run_job(1, 0, 0);

        run_job(MAX_VECS, 0, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
